// File: rtl/ps2_scan_controller.sv
// Purpose: validate PS/2 frames, fold Set-2 E0/F0 prefixes into key events, track modifiers, queue events.
// Latency: an event decoded on a frame_valid edge is visible on event_valid the next cycle (FIFO empty).
// Backpressure: event_valid/event_ready pop; when the FIFO is full with no pop the new event drops and overflow pulses.
module ps2_scan_controller #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit REQUIRE_BAT    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] frame,
  input  logic        frame_valid,
  output logic [7:0]  event_code,
  output logic        event_extended,
  output logic        event_release,
  output logic        event_valid,
  input  logic        event_ready,
  output logic [2:0]  modifiers,
  output logic        kbd_ready,
  output logic        frame_error,
  output logic        overflow,
  output logic        resync_req
);

  localparam logic [2:0] ST_WAIT_BAT = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_GOT_E0   = 3'd2;
  localparam logic [2:0] ST_GOT_F0   = 3'd3;
  localparam logic [2:0] ST_GOT_E0F0 = 3'd4;

  localparam logic [2:0] RST_STATE = REQUIRE_BAT ? ST_WAIT_BAT : ST_IDLE;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  logic [7:0]    data;
  logic          frame_ok;
  logic          in_seq;
  logic          timeout;

  logic          dec_vld;
  key_event_t    dec_ev;
  logic          set_kbd, clr_kbd, clr_mods;
  logic          err_nxt, resync_nxt;

  logic          l_shift, r_shift, l_ctrl, r_ctrl, l_alt, r_alt;

  key_event_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  key_event_t    head;

  assign data     = frame[8:1];
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
  assign in_seq   = (state == ST_GOT_E0) || (state == ST_GOT_F0) || (state == ST_GOT_E0F0);
  // A sequence is abandoned only if the counter has already sat at its last value and no byte arrives now.
  assign timeout  = in_seq && !frame_valid && (tmo_cnt == TO_LAST);

  // Byte decode: next state, event to emit and side effects for this edge.
  always_comb begin
    state_nxt  = state;
    dec_vld    = 1'b0;
    dec_ev     = '{ext: 1'b0, rel: 1'b0, code: data};
    set_kbd    = 1'b0;
    clr_kbd    = 1'b0;
    clr_mods   = 1'b0;
    err_nxt    = 1'b0;
    resync_nxt = 1'b0;
    if (frame_valid) begin
      if (!frame_ok) begin
        err_nxt = 1'b1;
        if (state != ST_WAIT_BAT) state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_WAIT_BAT: begin
            if (data == 8'hAA) begin
              set_kbd   = 1'b1;
              state_nxt = ST_IDLE;
            end else if (data == 8'hFC) begin
              resync_nxt = 1'b1;
            end
          end
          ST_IDLE: begin
            case (data)
              8'hE0: state_nxt = ST_GOT_E0;
              8'hF0: state_nxt = ST_GOT_F0;
              8'hAA: set_kbd = 1'b1;
              8'hFC: begin
                resync_nxt = 1'b1;
                clr_kbd    = 1'b1;
                clr_mods   = 1'b1;
                state_nxt  = ST_WAIT_BAT;
              end
              8'h00, 8'hFF: err_nxt = 1'b1;
              8'hFA, 8'hFE, 8'hEE: ;
              default: dec_vld = 1'b1;
            endcase
          end
          ST_GOT_E0: begin
            if (data == 8'hF0) begin
              state_nxt = ST_GOT_E0F0;
            end else if (data != 8'hE0) begin
              dec_vld    = 1'b1;
              dec_ev.ext = 1'b1;
              state_nxt  = ST_IDLE;
            end
          end
          ST_GOT_F0: begin
            dec_vld    = 1'b1;
            dec_ev.rel = 1'b1;
            state_nxt  = ST_IDLE;
          end
          ST_GOT_E0F0: begin
            dec_vld    = 1'b1;
            dec_ev.ext = 1'b1;
            dec_ev.rel = 1'b1;
            state_nxt  = ST_IDLE;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end else if (timeout) begin
      resync_nxt = 1'b1;
      state_nxt  = ST_IDLE;
    end
  end

  // Sequencer state, inter-byte timer, status flags and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RST_STATE;
      tmo_cnt     <= '0;
      kbd_ready   <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
      resync_req  <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_error <= err_nxt;
      overflow    <= dec_vld && !push;
      resync_req  <= resync_nxt;
      if (frame_valid || !in_seq || timeout) tmo_cnt <= '0;
      else                                   tmo_cnt <= tmo_cnt + CW'(1);
      if (clr_kbd)      kbd_ready <= 1'b0;
      else if (set_kbd) kbd_ready <= 1'b1;
    end
  end

  // Modifier tracking follows every decoded event, even one the FIFO has to drop.
  always_ff @(posedge clk) begin
    if (rst || clr_mods) begin
      {l_shift, r_shift, l_ctrl, r_ctrl, l_alt, r_alt} <= '0;
    end else if (dec_vld) begin
      case (dec_ev.code)
        8'h12: if (!dec_ev.ext) l_shift <= !dec_ev.rel;
        8'h59: if (!dec_ev.ext) r_shift <= !dec_ev.rel;
        8'h14: if (dec_ev.ext) r_ctrl <= !dec_ev.rel; else l_ctrl <= !dec_ev.rel;
        8'h11: if (dec_ev.ext) r_alt  <= !dec_ev.rel; else l_alt  <= !dec_ev.rel;
        default: ;
      endcase
    end
  end

  assign modifiers = {l_alt | r_alt, l_ctrl | r_ctrl, l_shift | r_shift};

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign pop  = event_valid && event_ready;
  assign push = dec_vld && ((count != CNT_FULL) || pop);

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since event_valid gates the outputs.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec_ev;
  end

  assign head           = mem[rd_ptr];
  assign event_valid    = (count != '0);
  assign event_code     = event_valid ? head.code : 8'h00;
  assign event_extended = event_valid & head.ext;
  assign event_release  = event_valid & head.rel;

endmodule
